// File: rtl/negator_sched_pkg.sv
// Shared types and constants for the negator scheduler: FSM states,
// error-status bit positions and parameter limits.
package negator_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_SPURIOUS = 1;

    // Below this the datapath cannot realistically answer before the abort.
    localparam int MIN_TIMEOUT = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/negator_scheduler_arbiter.sv
// Combinational rotate-priority arbiter: the search starts one above the
// previous winner and wraps, so every requester is reached within N grants.
module rr_arbiter
    import negator_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_grant) + k) % N);
            if (enable && !found && req[cand]) begin
                found              = 1'b1;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/negator_scheduler.sv
// Shares one single-transaction negator datapath between NUM_REQ clients:
// round-robin grant, issue, bounded wait for the result, then respond.
module negator_scheduler
    import negator_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic                      dp_input_valid,
    output logic [DATA_W-1:0]         dp_input_data,
    input  logic                      dp_output_valid,
    input  logic [DATA_W-1:0]         dp_output_data,
    output logic                      busy,
    output logic [1:0]                err_status,
    input  logic                      err_clear,
    output state_t                    dbg_state
);

    // Handshakes: a request transfers in the cycle req_valid[i] and
    // req_ready[i] are both high; a response transfers when resp_valid[i]
    // and resp_ready[i] are both high, and is held unchanged until then.
    // The datapath side is pulse-only: no back-pressure in either direction.

    localparam int IW  = idx_w(NUM_REQ);
    localparam int TMO = (TIMEOUT < MIN_TIMEOUT) ? MIN_TIMEOUT : TIMEOUT;
    localparam int CW  = idx_w(TMO);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TMO - 1);

    state_t              state;
    logic [DATA_W-1:0]   job_buf;
    logic [DATA_W-1:0]   resp_buf;
    logic                err_flag;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       last_grant;
    logic [CW-1:0]       wait_cnt;

    logic [NUM_REQ-1:0]  grant_onehot;
    logic [IW-1:0]       grant_idx;
    logic [DATA_W-1:0]   grant_data;
    logic [1:0]          err_set;
    logic                timeout_hit;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arbiter (
        .req          (req_valid),
        .last_grant   (last_grant),
        .enable       ((state == IDLE) && !reset),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout_hit = (state == WAIT) && !dp_output_valid && (wait_cnt == WAIT_LAST);

    always_comb begin
        err_set               = 2'b00;
        err_set[ERR_TIMEOUT]  = timeout_hit;
        err_set[ERR_SPURIOUS] = dp_output_valid && (state != WAIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            job_buf    <= '0;
            resp_buf   <= '0;
            err_flag   <= 1'b0;
            owner      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            wait_cnt   <= '0;
            err_status <= 2'b00;
        end else begin
            // A new error event in the clearing cycle survives the clear.
            err_status <= (err_clear ? 2'b00 : err_status) | err_set;
            case (state)
                IDLE: begin
                    if (|grant_onehot) begin
                        job_buf    <= grant_data;
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (dp_output_valid) begin
                        resp_buf <= dp_output_data;
                        err_flag <= 1'b0;
                        state    <= RESP;
                    end else if (timeout_hit) begin
                        resp_buf <= '0;
                        err_flag <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state, so an asynchronous
    // reset forces them to zero without waiting for a clock edge.
    always_comb begin
        resp_valid = '0;
        if (state == RESP) begin
            resp_valid[owner] = 1'b1;
        end
    end

    assign req_ready      = grant_onehot;
    assign resp_data      = (state == RESP) ? resp_buf : '0;
    assign resp_err       = (state == RESP) && err_flag;
    assign dp_input_valid = (state == ISSUE);
    assign dp_input_data  = (state == ISSUE) ? job_buf : '0;
    assign busy           = (state != IDLE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_negator_scheduler.sv
// Directed bench for negator_scheduler: arbitration order, latency,
// back-pressure, timeout, spurious results and asynchronous reset.
module tb_negator_scheduler;
    import negator_sched_pkg::*;

    localparam int NR = 4;
    localparam int DW = 64;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic [NR-1:0]     resp_ready;
    logic              dp_input_valid;
    logic [DW-1:0]     dp_input_data;
    logic              dp_output_valid;
    logic [DW-1:0]     dp_output_data;
    logic              busy;
    logic [1:0]        err_status;
    logic              err_clear;
    state_t            dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] job_tab [4];
    logic [63:0] neg_tab [4];

    negator_scheduler #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .resp_ready      (resp_ready),
        .dp_input_valid  (dp_input_valid),
        .dp_input_data   (dp_input_data),
        .dp_output_valid (dp_output_valid),
        .dp_output_data  (dp_output_data),
        .busy            (busy),
        .err_status      (err_status),
        .err_clear       (err_clear),
        .dbg_state       (dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // External datapath behaviour: two's-complement negate per 32-bit lane.
    function automatic logic [63:0] dp_negate(input logic [63:0] x);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = ~x[63:32] + 32'd1;
        lo = ~x[31:0] + 32'd1;
        return {hi, lo};
    endfunction

    // Entered at the negedge of the accept cycle T; returns at the negedge
    // after the response is taken, with the scheduler back in IDLE.
    task automatic serve(input int who, input int lat, input int hold,
                         input logic [63:0] job, input logic [63:0] exp_res);
        logic [3:0]  own;
        logic [63:0] captured;
        own = 4'b0001 << who;
        #1;
        chk($sformatf("req_ready_r%0d", who), req_ready, own);
        @(negedge clock);
        chk("issue_valid", dp_input_valid, 1'b1);
        chk("issue_data", dp_input_data, job);
        chk("issue_state", dbg_state, ISSUE);
        captured = dp_input_data;
        @(negedge clock);
        chk("issue_pulse_end", dp_input_valid, 1'b0);
        chk("issue_data_zero", dp_input_data, 64'd0);
        repeat (lat - 1) @(negedge clock);
        chk("no_early_resp", resp_valid, 4'b0000);
        dp_output_valid = 1'b1;
        dp_output_data  = dp_negate(captured);
        @(negedge clock);
        dp_output_valid = 1'b0;
        dp_output_data  = '0;
        chk($sformatf("resp_valid_r%0d", who), resp_valid, own);
        chk("resp_data", resp_data, exp_res);
        chk("resp_err", resp_err, 1'b0);
        resp_ready = ~own;
        for (int c = 0; c < hold; c++) begin
            @(negedge clock);
            chk("bp_resp_valid", resp_valid, own);
            chk("bp_resp_data", resp_data, exp_res);
            chk("bp_req_ready", req_ready, 4'b0000);
        end
        resp_ready = own;
        @(negedge clock);
        resp_ready = '0;
        chk("resp_done_valid", resp_valid, 4'b0000);
        chk("resp_done_idle", dbg_state, IDLE);
    endtask

    initial begin
        job_tab[0] = 64'h00000001_00000002;
        job_tab[1] = 64'h00000010_00000020;
        job_tab[2] = 64'h00000100_FFFFFFFF;
        job_tab[3] = 64'h7FFFFFFF_80000000;
        neg_tab[0] = 64'hFFFFFFFF_FFFFFFFE;
        neg_tab[1] = 64'hFFFFFFF0_FFFFFFE0;
        neg_tab[2] = 64'hFFFFFF00_00000001;
        neg_tab[3] = 64'h80000001_80000000;

        reset           = 1'b1;
        req_valid       = 4'b1111;
        req_data        = '0;
        resp_ready      = '0;
        dp_output_valid = 1'b0;
        dp_output_data  = '0;
        err_clear       = 1'b0;
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = job_tab[i];

        // Reset state, with all requesters already asking.
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_resp_valid", resp_valid, 4'b0000);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_dp_valid", dp_input_valid, 1'b0);
        chk("rst_dp_data", dp_input_data, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err_status", err_status, 2'b00);
        chk("rst_state", dbg_state, IDLE);

        // All four continuously valid: grants 0,1,2,3,0; requester 1 is back-pressured.
        @(negedge clock);
        reset = 1'b0;
        serve(0, 3, 0, job_tab[0], neg_tab[0]);
        serve(1, 3, 10, job_tab[1], neg_tab[1]);
        serve(2, 3, 0, job_tab[2], neg_tab[2]);
        serve(3, 3, 0, job_tab[3], neg_tab[3]);
        serve(0, 3, 0, job_tab[0], neg_tab[0]);
        req_valid = '0;

        // Single job from requester 2.
        @(negedge clock);
        req_valid = 4'b0100;
        req_data[2*DW +: DW] = 64'h00000005_00000003;
        serve(2, 3, 0, 64'h00000005_00000003, 64'hFFFFFFFB_FFFFFFFD);
        req_valid = '0;

        // Result arriving in the last WAIT cycle beats the timeout.
        @(negedge clock);
        req_valid = 4'b0001;
        serve(0, 16, 0, job_tab[0], neg_tab[0]);
        chk("coincide_no_err", err_status, 2'b00);

        // Datapath silent: abort after 16 WAIT cycles.
        #1;
        chk("tmo_req_ready", req_ready, 4'b0001);
        @(negedge clock);
        req_valid = '0;
        repeat (16) @(negedge clock);
        chk("tmo_not_yet", resp_valid, 4'b0000);
        chk("tmo_not_yet_err", err_status, 2'b00);
        @(negedge clock);
        chk("tmo_resp_valid", resp_valid, 4'b0001);
        chk("tmo_resp_err", resp_err, 1'b1);
        chk("tmo_resp_data", resp_data, 64'd0);
        chk("tmo_err_status", err_status, 2'b01);
        resp_ready = 4'b0001;
        @(negedge clock);
        resp_ready = '0;
        chk("tmo_err_outside", resp_err, 1'b0);
        chk("tmo_sticky", err_status, 2'b01);
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        chk("tmo_cleared", err_status, 2'b00);

        // Spurious result while idle, then set-beats-clear.
        dp_output_valid = 1'b1;
        dp_output_data  = 64'h0000_0000_0000_0123;
        @(negedge clock);
        dp_output_valid = 1'b0;
        dp_output_data  = '0;
        chk("spur_err_status", err_status, 2'b10);
        chk("spur_no_resp", resp_valid, 4'b0000);
        chk("spur_idle", dbg_state, IDLE);
        chk("spur_busy", busy, 1'b0);
        dp_output_valid = 1'b1;
        err_clear       = 1'b1;
        @(negedge clock);
        dp_output_valid = 1'b0;
        err_clear       = 1'b0;
        chk("set_beats_clear", err_status, 2'b10);
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        chk("spur_cleared", err_status, 2'b00);

        // Reset asserted while waiting on the datapath.
        req_valid = 4'b1000;
        #1;
        chk("rw_req_ready", req_ready, 4'b1000);
        @(negedge clock);
        req_valid = '0;
        repeat (2) @(negedge clock);
        chk("rw_in_wait", dbg_state, WAIT);
        req_valid = 4'b1000;
        reset     = 1'b1;
        #1;
        chk("rw_busy", busy, 1'b0);
        chk("rw_state", dbg_state, IDLE);
        chk("rw_req_ready", req_ready, 4'b0000);
        chk("rw_resp_valid", resp_valid, 4'b0000);
        chk("rw_dp_valid", dp_input_valid, 1'b0);
        @(negedge clock);
        reset     = 1'b0;
        req_valid = '0;
        dp_output_valid = 1'b1;
        dp_output_data  = dp_negate(job_tab[3]);
        @(negedge clock);
        dp_output_valid = 1'b0;
        dp_output_data  = '0;
        chk("late_err_status", err_status, 2'b10);
        chk("late_no_resp", resp_valid, 4'b0000);
        chk("late_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
